fetch_stage: RTL and testbench

- First pipeline stage and upstream producer for the decode stage.
- Issues instruction-memory reads at the program counter and presents {program_count, instruction_data} to decode over the done_next/next_stall handshake.
- Applies control-flow redirects (control_flow_affected, jump_target, jump_target_valid) that decode drives back.
- Single outstanding memory request; not a prefetcher.

---
 rtl/fetch_stage.sv | 184 ++++++++++++++++++
 tb/tb_fetch_stage.sv | 417 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Fetch stage: one outstanding imem read, presents {pc, insn} to decode.
// Optional misaligned-redirect trap enabled by FETCH_MISALIGN_TRAP_EN.
module fetch_stage #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        next_stall,
    output logic        done_next,
    input  logic        control_flow_affected,
    input  logic [31:0] jump_target,
    input  logic        jump_target_valid,
    output logic [31:0] imem_request_addr,
    output logic        imem_request_valid,
    input  logic        imem_request_ready,
    input  logic [31:0] imem_response_data,
    input  logic        imem_response_valid,
    output logic [31:0] program_count_out,
    output logic        program_count_valid_out,
    output logic [31:0] instruction_data_out,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic        instruction_misaligned_out,
`endif
    output logic        instruction_data_valid_out
);

    localparam int ADDR_WIDTH        = 32;
    localparam int INSTRUCTION_WIDTH = 32;

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2,
        S_TRAP = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [ADDR_WIDTH-1:0]        pc;
    logic [ADDR_WIDTH-1:0]        pc_q;
    logic [ADDR_WIDTH-1:0]        target_pc;
    logic [INSTRUCTION_WIDTH-1:0] instr_q;
    logic                         pc_vld_q;
    logic                         ins_vld_q;
    logic                         squash;

    logic redirect;
    logic handshake;
    logic transfer;
    logic rsp_in_wait;
    logic drop_rsp;
    logic trap_jump;
    logic trap_live;

    assign redirect    = control_flow_affected && jump_target_valid;
    assign handshake   = imem_request_valid && imem_request_ready;
    assign transfer    = done_next && !next_stall;
    assign rsp_in_wait = (state == S_WAIT) && imem_response_valid;
    assign drop_rsp    = squash || redirect;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic trap_done;
    logic mis_q;

    assign trap_jump = redirect && (jump_target[1:0] != 2'b00);
    assign target_pc = jump_target;
    assign trap_live = (state == S_TRAP) && !trap_done;
`else
    assign trap_jump = 1'b0;
    // Low bits are dropped so pc always stays word aligned.
    assign target_pc = jump_target & ~ADDR_WIDTH'(3);
    assign trap_live = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        if (trap_jump) begin
            state_next = S_TRAP;
        end else begin
            unique case (state)
                S_REQ: begin
                    if (handshake) state_next = S_WAIT;
                end
                S_WAIT: begin
                    if (imem_response_valid)
                        state_next = drop_rsp ? S_REQ : S_HOLD;
                end
                S_HOLD: begin
                    if (redirect || transfer) state_next = S_REQ;
                end
                S_TRAP: begin
                    if (redirect) state_next = S_REQ;
                end
            endcase
        end
    end

    // Any control_flow_affected gates both handshakes in the same cycle.
    always_comb begin
        imem_request_valid = 1'b0;
        done_next          = 1'b0;
        if (!rst && !control_flow_affected) begin
            imem_request_valid = (state == S_REQ);
            done_next          = (state == S_HOLD) || trap_live;
        end
    end

    assign imem_request_addr = pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc     <= RESET_VECTOR;
            squash <= 1'b0;
        end else begin
            if (redirect) begin
                pc <= target_pc;
            end else if (rsp_in_wait && !squash) begin
                pc <= pc + ADDR_WIDTH'(4);
            end
            if (rsp_in_wait) begin
                squash <= 1'b0;
            end else if ((state == S_WAIT) && redirect) begin
                squash <= 1'b1;
            end else if ((state == S_TRAP) && imem_response_valid) begin
                squash <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= '0;
            instr_q   <= '0;
            pc_vld_q  <= 1'b0;
            ins_vld_q <= 1'b0;
        end else if (trap_jump) begin
            pc_q      <= jump_target;
            pc_vld_q  <= 1'b1;
            ins_vld_q <= 1'b0;
        end else if (rsp_in_wait && !drop_rsp) begin
            pc_q      <= pc;
            instr_q   <= imem_response_data;
            pc_vld_q  <= 1'b1;
            ins_vld_q <= 1'b1;
        end else if (((state == S_HOLD) || (state == S_TRAP))
                     && (redirect || transfer)) begin
            pc_vld_q  <= 1'b0;
            ins_vld_q <= 1'b0;
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    // After the trap is handed over the stage idles until redirected.
    always_ff @(posedge clk) begin
        if (rst) begin
            mis_q     <= 1'b0;
            trap_done <= 1'b0;
        end else if (trap_jump) begin
            mis_q     <= 1'b1;
            trap_done <= 1'b0;
        end else if ((state == S_TRAP) && (redirect || transfer)) begin
            mis_q     <= 1'b0;
            trap_done <= transfer;
        end
    end

    assign instruction_misaligned_out = mis_q;
`endif

    assign program_count_out          = pc_q;
    assign program_count_valid_out    = pc_vld_q;
    assign instruction_data_out       = instr_q;
    assign instruction_data_valid_out = ins_vld_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory model, fetch-stream scoreboard,
// and hand-computed checks of the key scenarios.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        next_stall;
    logic        done_next;
    logic        control_flow_affected;
    logic [31:0] jump_target;
    logic        jump_target_valid;
    logic [31:0] imem_request_addr;
    logic        imem_request_valid;
    logic        imem_request_ready;
    logic [31:0] imem_response_data;
    logic        imem_response_valid;
    logic [31:0] program_count_out;
    logic        program_count_valid_out;
    logic [31:0] instruction_data_out;
    logic        instruction_data_valid_out;
    logic        instruction_misaligned_out;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
    assign instruction_misaligned_out = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    int lat   = 1;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk                        (clk),
        .rst                        (rst),
        .next_stall                 (next_stall),
        .done_next                  (done_next),
        .control_flow_affected      (control_flow_affected),
        .jump_target                (jump_target),
        .jump_target_valid          (jump_target_valid),
        .imem_request_addr          (imem_request_addr),
        .imem_request_valid         (imem_request_valid),
        .imem_request_ready         (imem_request_ready),
        .imem_response_data         (imem_response_data),
        .imem_response_valid        (imem_response_valid),
        .program_count_out          (program_count_out),
        .program_count_valid_out    (program_count_valid_out),
        .instruction_data_out       (instruction_data_out),
`ifdef FETCH_MISALIGN_TRAP_EN
        .instruction_misaligned_out (instruction_misaligned_out),
`endif
        .instruction_data_valid_out (instruction_data_valid_out)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h13 | (a << 5);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_done(input int lim, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < lim && !hit; i++) begin
            @(negedge clk);
            if (done_next) hit = 1'b1;
            else nxt();
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL %s: no done_next within %0d cycles", nm, lim);
        end
    endtask

    task automatic wait_req(input int lim, input string nm);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < lim && !hit; i++) begin
            @(negedge clk);
            if (imem_request_valid) hit = 1'b1;
            else nxt();
        end
        total++;
        if (!hit) begin
            bad++;
            $display("FAIL %s: no request within %0d cycles", nm, lim);
        end
    endtask

    // Memory: accepts when ready, answers after lat cycles.
    initial begin : memory
        bit          acc;
        bit          busy;
        int          cnt;
        logic [31:0] a;
        logic [31:0] a_s;
        busy = 1'b0;
        cnt  = 0;
        a    = '0;
        imem_response_valid = 1'b0;
        imem_response_data  = '0;
        forever begin
            @(negedge clk);
            acc = imem_request_valid && imem_request_ready && !rst;
            a_s = imem_request_addr;
            @(posedge clk);
            #1;
            imem_response_valid = 1'b0;
            if (rst) busy = 1'b0;
            if (acc) begin
                busy = 1'b1;
                cnt  = lat;
                a    = a_s;
            end
            if (busy) begin
                cnt--;
                if (cnt <= 0) begin
                    imem_response_valid = 1'b1;
                    imem_response_data  = mem_word(a);
                    busy = 1'b0;
                end
            end
        end
    end

    // Scoreboard: m_pc is the next instruction decode should receive.
    logic [31:0] m_pc;
    logic [31:0] m_trap_pc;
    logic [31:0] prev_pc;
    logic [31:0] prev_ins;
    bit          m_trap;
    bit          prev_hold;

    initial begin : compare
        m_pc = '0;
        m_trap = 1'b0;
        m_trap_pc = '0;
        prev_hold = 1'b0;
        prev_pc = '0;
        prev_ins = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_pc = 32'h0;
                m_trap = 1'b0;
                prev_hold = 1'b0;
            end else begin
                if (control_flow_affected) begin
                    chk("gate_done", done_next, 0);
                    chk("gate_req", imem_request_valid, 0);
                end
                if (prev_hold && !control_flow_affected) begin
                    chk("stall_done", done_next, 1);
                    chk("stall_pc", program_count_out, prev_pc);
                    chk("stall_ins", instruction_data_out, prev_ins);
                end
                if (instruction_data_valid_out) begin
                    chk("ins_mem", instruction_data_out,
                        mem_word(program_count_out));
                    chk("pc_vld", program_count_valid_out, 1);
                end
                if (imem_request_valid && imem_request_ready) begin
                    if (m_trap) chk("trap_noreq", imem_request_valid, 0);
                    else chk("req_addr", imem_request_addr, m_pc);
                end
                if (done_next && !next_stall) begin
                    if (m_trap) begin
                        chk("trap_pc", program_count_out, m_trap_pc);
                        chk("trap_mis", instruction_misaligned_out, 1);
                        chk("trap_iv", instruction_data_valid_out, 0);
                    end else begin
                        chk("xfer_pc", program_count_out, m_pc);
                        chk("xfer_ins", instruction_data_out, mem_word(m_pc));
                        chk("xfer_iv", instruction_data_valid_out, 1);
                        m_pc = m_pc + 32'd4;
                    end
                end
                if (control_flow_affected && jump_target_valid) begin
                    if (TRAP_EN && jump_target[1:0] != 2'b00) begin
                        m_trap = 1'b1;
                        m_trap_pc = jump_target;
                    end else begin
                        m_trap = 1'b0;
                        m_pc = jump_target & ~32'h3;
                    end
                end
                prev_hold = done_next && next_stall;
                prev_pc = program_count_out;
                prev_ins = instruction_data_out;
            end
        end
    end

    initial begin : guard
        #50000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1, "timeout");
    end

    initial begin : stim
        rst = 1'b1;
        next_stall = 1'b0;
        control_flow_affected = 1'b0;
        jump_target = '0;
        jump_target_valid = 1'b0;
        imem_request_ready = 1'b1;

        repeat (2) @(posedge clk);
        #2;
        @(negedge clk);
        chk("rst_done", done_next, 0);
        chk("rst_req", imem_request_valid, 0);
        chk("rst_pcv", program_count_valid_out, 0);
        chk("rst_iv", instruction_data_valid_out, 0);
        chk("rst_pc", program_count_out, 0);
        chk("rst_ins", instruction_data_out, 0);
        nxt();
        rst = 1'b0;

        @(negedge clk);
        chk("c1_req", imem_request_valid, 1);
        chk("c1_addr", imem_request_addr, 32'h0);
        nxt();
        @(negedge clk);
        chk("c2_req", imem_request_valid, 0);
        chk("c2_done", done_next, 0);
        nxt();
        @(negedge clk);
        chk("c3_done", done_next, 1);
        chk("c3_pc", program_count_out, 32'h0);
        chk("c3_ins", instruction_data_out, 32'h13);
        nxt();
        next_stall = 1'b1;
        @(negedge clk);
        chk("c4_req", imem_request_valid, 1);
        chk("c4_addr", imem_request_addr, 32'h4);

        wait_done(10, "hold4");
        chk("h4_pc", program_count_out, 32'h4);
        chk("h4_ins", instruction_data_out, 32'h93);
        repeat (5) begin
            nxt();
            @(negedge clk);
            chk("st_done", done_next, 1);
            chk("st_req", imem_request_valid, 0);
            chk("st_pc", program_count_out, 32'h4);
        end
        nxt();
        next_stall = 1'b0;
        @(negedge clk);
        chk("rel_done", done_next, 1);
        nxt();
        next_stall = 1'b1;
        @(negedge clk);
        chk("r8_req", imem_request_valid, 1);
        chk("r8_addr", imem_request_addr, 32'h8);

        wait_done(10, "hold8");
        chk("h8_pc", program_count_out, 32'h8);
        nxt();
        control_flow_affected = 1'b1;
        jump_target_valid = 1'b1;
        jump_target = 32'h100;
        next_stall = 1'b0;
        @(negedge clk);
        chk("rdh_done", done_next, 0);
        chk("rdh_req", imem_request_valid, 0);
        nxt();
        control_flow_affected = 1'b0;
        jump_target_valid = 1'b0;
        @(negedge clk);
        chk("r100_addr", imem_request_addr, 32'h100);
        chk("r100_req", imem_request_valid, 1);

        nxt();
        lat = 3;
        wait_req(20, "req104");
        chk("r104_addr", imem_request_addr, 32'h104);
        nxt();
        control_flow_affected = 1'b1;
        jump_target_valid = 1'b1;
        jump_target = 32'h40;
        @(negedge clk);
        chk("rdw_req", imem_request_valid, 0);
        chk("rdw_done", done_next, 0);
        nxt();
        control_flow_affected = 1'b0;
        jump_target_valid = 1'b0;
        @(negedge clk);
        chk("rdw_req2", imem_request_valid, 0);
        nxt();
        @(negedge clk);
        chk("rdw_drop_req", imem_request_valid, 0);
        chk("rdw_drop_done", done_next, 0);
        nxt();
        @(negedge clk);
        chk("r40_req", imem_request_valid, 1);
        chk("r40_addr", imem_request_addr, 32'h40);

        nxt();
        control_flow_affected = 1'b1;
        jump_target_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("pend_done", done_next, 0);
            chk("pend_req", imem_request_valid, 0);
            nxt();
        end
        control_flow_affected = 1'b0;
        @(negedge clk);
        chk("nt_done", done_next, 1);
        chk("nt_pc", program_count_out, 32'h40);
        chk("nt_ins", instruction_data_out, 32'h813);
        nxt();
        lat = 1;
        @(negedge clk);
        chk("r44_req", imem_request_valid, 1);
        chk("r44_addr", imem_request_addr, 32'h44);

        nxt();
        control_flow_affected = 1'b1;
        jump_target_valid = 1'b1;
        jump_target = 32'hFFFF_FFFC;
        @(negedge clk);
        chk("rdwrap_done", done_next, 0);
        nxt();
        control_flow_affected = 1'b0;
        jump_target_valid = 1'b0;
        @(negedge clk);
        chk("rtop_req", imem_request_valid, 1);
        chk("rtop_addr", imem_request_addr, 32'hFFFF_FFFC);
        wait_done(10, "holdtop");
        chk("htop_pc", program_count_out, 32'hFFFF_FFFC);
        chk("htop_ins", instruction_data_out, 32'hFFFF_FF93);
        nxt();
        @(negedge clk);
        chk("wrap_req", imem_request_valid, 1);
        chk("wrap_addr", imem_request_addr, 32'h0);

        nxt();
        control_flow_affected = 1'b1;
        jump_target_valid = 1'b1;
        jump_target = 32'h102;
        @(negedge clk);
        chk("mis_gate", done_next, 0);
        nxt();
        control_flow_affected = 1'b0;
        jump_target_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        @(negedge clk);
        chk("trp_done", done_next, 1);
        chk("trp_pc", program_count_out, 32'h102);
        chk("trp_mis", instruction_misaligned_out, 1);
        chk("trp_pcv", program_count_valid_out, 1);
        chk("trp_iv", instruction_data_valid_out, 0);
        chk("trp_req", imem_request_valid, 0);
        repeat (4) begin
            nxt();
            @(negedge clk);
            chk("trp_idle_req", imem_request_valid, 0);
            chk("trp_idle_done", done_next, 0);
        end
        nxt();
        control_flow_affected = 1'b1;
        jump_target_valid = 1'b1;
        jump_target = 32'h200;
        nxt();
        control_flow_affected = 1'b0;
        jump_target_valid = 1'b0;
        @(negedge clk);
        chk("r200_req", imem_request_valid, 1);
        chk("r200_addr", imem_request_addr, 32'h200);
`else
        @(negedge clk);
        chk("al_req", imem_request_valid, 1);
        chk("al_addr", imem_request_addr, 32'h100);
`endif

        nxt();
        lat = 3;
        wait_req(20, "req_pre_rst");
        nxt();
        rst = 1'b1;
        @(negedge clk);
        chk("rw_done", done_next, 0);
        chk("rw_req", imem_request_valid, 0);
        nxt();
        rst = 1'b0;
        @(negedge clk);
        chk("rr_req", imem_request_valid, 1);
        chk("rr_addr", imem_request_addr, 32'h0);
        wait_done(20, "hold_after_rst");
        chk("rr_pc", program_count_out, 32'h0);
        chk("rr_ins", instruction_data_out, 32'h13);

        repeat (12) nxt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
